// File: rtl/fuzz_stim_driver_if.sv
// Bundle of control, stimulus and response signals between the
// fuzz stimulus engine and its controller / DUT side.
interface fuzz_stim_driver_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 8,
    parameter int RESP_W = 16,
    parameter int CW     = 5
);
    logic                     start;
    logic [31:0]              seed;
    logic [NUM_CH-1:0]        hold;
    logic [RESP_W-1:0]        resp;
    logic [NUM_CH*CH_W-1:0]   stim;
    logic                     stim_valid;
    logic [CW-1:0]            cyc_cnt;
    logic [RESP_W-1:0]        sig;
    logic                     done;

    // Controller / DUT side: issues runs, returns the DUT response.
    modport master (
        output start, seed, hold, resp,
        input  stim, stim_valid, cyc_cnt, sig, done
    );

    // Stimulus engine side.
    modport slave (
        input  start, seed, hold, resp,
        output stim, stim_valid, cyc_cnt, sig, done
    );
endinterface

// File: rtl/fuzz_stim_driver.sv
// fuzz_stim_driver: restartable, seed-controlled multi-channel stimulus
// engine. Each channel runs its own 32-bit Galois LFSR; the DUT response
// is compacted into a rotate-xor signature while stim is live.

// One stimulus channel: a 32-bit Galois LFSR seeded from the base seed
// salted by the channel index, so channels never share a sequence.
module fuzz_stim_lane #(
    parameter int CH   = 0,
    parameter int CH_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            hold,
    input  logic [31:0]     seed,
    output logic [CH_W-1:0] val
);
    localparam logic [31:0] SALT = 32'(CH) * 32'h9E37_79B9;
    localparam logic [31:0] TAPS = 32'h0040_0007;

    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;
    logic [31:0] ld_raw;
    logic [31:0] ld_val;

    // Load value (with all-zero lock-up guard) and next LFSR state.
    always_comb begin
        ld_raw   = seed ^ SALT;
        ld_val   = (ld_raw == 32'h0) ? 32'h0000_0001 : ld_raw;
        lfsr_nxt = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? TAPS : 32'h0);
    end

    // LFSR register: load on accepted start, step while running unless frozen.
    always_ff @(posedge clk) begin
        if (!rst_n)
            lfsr <= 32'h0;
        else if (load)
            lfsr <= ld_val;
        else if (step && !hold)
            lfsr <= lfsr_nxt;
    end

    assign val = lfsr[CH_W-1:0];
endmodule

module fuzz_stim_driver #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 8,
    parameter int RESP_W = 16,
    parameter int CYCLES = 20,
    parameter int CW     = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    fuzz_stim_driver_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A zero-length run skips RUN and completes immediately.
    localparam state_t        GO_STATE = (CYCLES == 0) ? ST_DONE : ST_RUN;
    localparam logic [CW-1:0] CYC_MAX  = CW'(CYCLES);
    localparam logic [CW-1:0] CYC_LAST = (CYCLES == 0) ? '0 : CW'(CYCLES - 1);

    state_t                       state;
    state_t                       state_nxt;
    logic                         accept;
    logic                         running;
    logic                         done_o;
    logic [CW-1:0]                cyc_cnt;
    logic [RESP_W-1:0]            sig;
    logic [NUM_CH-1:0][CH_W-1:0]  lane_val;

    // start is only honoured outside RUN; reset priority lives in the registers.
    assign accept = bus.start && (state != ST_RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: IDLE and DONE both launch a run; RUN ends on the last cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE,
            ST_DONE: if (accept) state_nxt = GO_STATE;
            ST_RUN:  if (cyc_cnt == CYC_LAST) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        running = (state == ST_RUN);
        done_o  = (state == ST_DONE);
    end

    // Cycle counter and response signature.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            sig     <= '0;
        end else if (accept) begin
            cyc_cnt <= '0;
            sig     <= '0;
        end else if (running) begin
            if (cyc_cnt != CYC_MAX)
                cyc_cnt <= cyc_cnt + 1'b1;
            sig <= {sig[RESP_W-2:0], sig[RESP_W-1]} ^ bus.resp;
        end
    end

    // One LFSR lane per channel.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        fuzz_stim_lane #(
            .CH   (c),
            .CH_W (CH_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept),
            .step  (running),
            .hold  (bus.hold[c]),
            .seed  (bus.seed),
            .val   (lane_val[c])
        );
    end

    assign bus.stim       = running ? lane_val : '0;
    assign bus.stim_valid = running;
    assign bus.cyc_cnt    = cyc_cnt;
    assign bus.sig        = sig;
    assign bus.done       = done_o;
endmodule
